// File: rtl/sdram_slot_arbiter.sv
// Shares the MiST SDRAM controller's single 8-bit CPU slot among the 6502 bus (A),
// the image loader (B) and aux DMA (C), one access per 24-clock sync frame.
module sdram_slot_arbiter #(
    parameter int FRAME_LEN  = 24,
    parameter int SLOT_PH    = 12,
    parameter int DATA_PH    = 18,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic        sd_ready,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [24:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [24:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [24:0] c_addr,
    input  logic [7:0]  c_wdata,
    output logic        c_ack,
    output logic [7:0]  c_rdata,
    output logic [24:0] sd_adr,
    output logic [7:0]  sd_di,
    output logic        sd_we,
    input  logic [7:0]  sd_do,
    output logic [1:0]  grant
);
    localparam logic [4:0] LAST_PH = 5'(FRAME_LEN - 1);
    localparam logic [4:0] ARB_PH  = 5'(SLOT_PH - 1);
    localparam logic [4:0] END_PH  = 5'(DATA_PH - 1);
    localparam logic [2:0] SMAX    = 3'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t     state;
    logic [4:0] ph;
    logic [2:0] sb, sc;
    logic       last_c;     // 1 = C was the last of B/C served
    logic [1:0] win;
    logic       arb;

    // Entry 0 is the "no owner" code so grant/win index these directly.
    logic [3:0]        req_v, we_v;
    logic [3:0][24:0]  addr_v;
    logic [3:0][7:0]   wdata_v;

    assign req_v   = {c_req, b_req, a_req, 1'b0};
    assign we_v    = {c_we, b_we, a_we, 1'b0};
    assign addr_v  = {c_addr, b_addr, a_addr, 25'd0};
    assign wdata_v = {c_wdata, b_wdata, a_wdata, 8'd0};

    always_comb begin
        logic starve_b, starve_c;
        starve_b = b_req && (sb == SMAX);
        starve_c = c_req && (sc == SMAX);
        win = 2'd0;
        if (starve_b && starve_c)   win = last_c ? 2'd2 : 2'd3;
        else if (starve_b)          win = 2'd2;
        else if (starve_c)          win = 2'd3;
        else if (a_req)             win = 2'd1;
        else if (b_req && c_req)    win = last_c ? 2'd2 : 2'd3;
        else if (b_req)             win = 2'd2;
        else if (c_req)             win = 2'd3;
    end

    // A sync landing on the arbitration clock restarts the frame, so skip it.
    assign arb = (state == IDLE) && (ph == ARB_PH) && sd_ready && !sync && (|req_v);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ph      <= LAST_PH;
            sb      <= 3'd0;
            sc      <= 3'd0;
            last_c  <= 1'b1;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            c_ack   <= 1'b0;
            a_rdata <= 8'd0;
            b_rdata <= 8'd0;
            c_rdata <= 8'd0;
            sd_adr  <= 25'd0;
            sd_di   <= 8'd0;
            sd_we   <= 1'b0;
            grant   <= 2'd0;
        end else begin
            ph    <= sync ? 5'd0 : (ph == LAST_PH ? ph : ph + 5'd1);
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            c_ack <= 1'b0;

            if (!b_req)                               sb <= 3'd0;
            else if (arb && win == 2'd1 && sb != 3'd7) sb <= sb + 3'd1;
            if (!c_req)                               sc <= 3'd0;
            else if (arb && win == 2'd1 && sc != 3'd7) sc <= sc + 3'd1;

            case (state)
                IDLE: if (arb) begin
                    grant  <= win;
                    sd_adr <= addr_v[win];
                    sd_di  <= wdata_v[win];
                    sd_we  <= we_v[win];
                    state  <= GRANT;
                end
                GRANT: begin
                    if (sync) begin
                        grant <= 2'd0;
                        sd_we <= 1'b0;
                        state <= IDLE;
                    end else if (ph == END_PH) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A dropped request still finishes the slot but gets no ack or data.
                    if (req_v[grant]) begin
                        case (grant)
                            2'd1: begin a_ack <= 1'b1; if (!sd_we) a_rdata <= sd_do; end
                            2'd2: begin b_ack <= 1'b1; if (!sd_we) b_rdata <= sd_do; end
                            2'd3: begin c_ack <= 1'b1; if (!sd_we) c_rdata <= sd_do; end
                            default: ;
                        endcase
                    end
                    if (grant == 2'd2) begin sb <= 3'd0; last_c <= 1'b0; end
                    if (grant == 2'd3) begin sc <= 3'd0; last_c <= 1'b1; end
                    grant <= 2'd0;
                    sd_we <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter: per-frame vector table plus hand sequences
// for sync abort, dropped request and mid-slot reset.
module tb_sdram_slot_arbiter;
    logic        clk = 1'b0;
    logic        reset, sync, sd_ready;
    logic        a_req, a_we, b_req, b_we, c_req, c_we;
    logic [24:0] a_addr, b_addr, c_addr;
    logic [7:0]  a_wdata, b_wdata, c_wdata;
    logic        a_ack, b_ack, c_ack;
    logic [7:0]  a_rdata, b_rdata, c_rdata;
    logic [24:0] sd_adr;
    logic [7:0]  sd_di, sd_do;
    logic        sd_we;
    logic [1:0]  grant;

    sdram_slot_arbiter dut (
        .clk(clk), .reset(reset), .sync(sync), .sd_ready(sd_ready),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
        .sd_adr(sd_adr), .sd_di(sd_di), .sd_we(sd_we), .sd_do(sd_do), .grant(grant)
    );

    always #5 clk = ~clk;

    localparam logic [24:0] ADR_A = 25'h0001235;
    localparam logic [24:0] ADR_B = 25'h0100000;
    localparam logic [24:0] ADR_C = 25'h0000AA1;

    typedef struct {
        logic       a, b, c, bwe, rdy;
        logic [7:0] rd;
        logic [1:0] g;
        logic       we;
        logic [7:0] di;
        logic [2:0] ack;   // {a,b,c}
    } vec_t;

    int          checks = 0, failures = 0;
    int          eph = 23;              // expected DUT phase
    logic        force_sync = 1'b0;
    logic [7:0]  cur_rd = 8'h00;
    int          ack_cnt[3];
    logic [7:0]  exp_rd[3];
    logic [24:0] tadr[4];
    vec_t        tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        sync = force_sync || (eph == 23);
        @(posedge clk);
        if (reset)           eph = 23;
        else if (sync)       eph = 0;
        else if (eph != 23)  eph++;
        #1;
        force_sync = 1'b0;
        sd_do = (eph >= 18) ? cur_rd : 8'hEE;
        ack_cnt[0] += int'(a_ack);
        ack_cnt[1] += int'(b_ack);
        ack_cnt[2] += int'(c_ack);
    endtask

    task automatic go_ph(input int target);
        int n = 0;
        do begin step(); n++; end while (eph != target && n < 60);
        if (eph != target) begin
            checks++; failures++;
            $display("FAIL go_ph timeout: got phase %0d expected %0d", eph, target);
        end
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 3; k++) ack_cnt[k] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tadr = '{25'd0, ADR_A, ADR_B, ADR_C};
        // {a,b,c,bwe,rdy, rd, grant,we,di, ack{a,b,c}}
        tbl[0]  = '{0,1,1,0,1, 8'h11, 2'd2, 1'b0, 8'h00, 3'b010};
        tbl[1]  = '{0,1,1,0,1, 8'h22, 2'd3, 1'b0, 8'h00, 3'b001};
        tbl[2]  = '{0,1,1,0,1, 8'h33, 2'd2, 1'b0, 8'h00, 3'b010};
        tbl[3]  = '{0,1,1,0,1, 8'h44, 2'd3, 1'b0, 8'h00, 3'b001};
        tbl[4]  = '{1,1,0,1,1, 8'h55, 2'd1, 1'b0, 8'h00, 3'b100};
        tbl[5]  = '{1,1,0,1,1, 8'h56, 2'd1, 1'b0, 8'h00, 3'b100};
        tbl[6]  = '{1,1,0,1,1, 8'h57, 2'd1, 1'b0, 8'h00, 3'b100};
        tbl[7]  = '{1,1,0,1,1, 8'h58, 2'd1, 1'b0, 8'h00, 3'b100};
        tbl[8]  = '{1,1,0,1,1, 8'h59, 2'd2, 1'b1, 8'h3F, 3'b010};
        tbl[9]  = '{1,1,1,0,0, 8'h61, 2'd0, 1'b0, 8'h00, 3'b000};
        tbl[10] = '{1,1,1,0,0, 8'h62, 2'd0, 1'b0, 8'h00, 3'b000};
        tbl[11] = '{1,1,1,0,1, 8'h66, 2'd1, 1'b0, 8'h00, 3'b100};

        reset = 1'b1; sync = 1'b0; sd_ready = 1'b1; sd_do = 8'hEE;
        a_req = 0; a_we = 0; a_addr = ADR_A; a_wdata = 8'h00;
        b_req = 0; b_we = 0; b_addr = ADR_B; b_wdata = 8'h3F;
        c_req = 0; c_we = 0; c_addr = ADR_C; c_wdata = 8'hC3;
        for (int k = 0; k < 3; k++) exp_rd[k] = 8'h00;
        clr_cnt();
        repeat (3) step();

        chk("reset grant", grant, 0);
        chk("reset sd_we", sd_we, 0);
        chk("reset sd_adr", sd_adr, 0);
        chk("reset sd_di", sd_di, 0);
        chk("reset acks", {a_ack, b_ack, c_ack}, 0);
        chk("reset rdata", {a_rdata, b_rdata, c_rdata}, 0);

        // Single A read: slot owns the bus from ph 12, ack registered out of ph 18.
        reset = 1'b0;
        a_req = 1'b1; cur_rd = 8'h5A;
        go_ph(12);
        chk("t1 grant", grant, 1);
        chk("t1 sd_adr@12", sd_adr, ADR_A);
        chk("t1 sd_we", sd_we, 0);
        go_ph(17);
        chk("t1 sd_adr@17", sd_adr, ADR_A);
        go_ph(18);
        chk("t1 no early ack", a_ack, 0);
        go_ph(19);
        chk("t1 a_ack", a_ack, 1);
        chk("t1 a_rdata", a_rdata, 8'h5A);
        exp_rd[0] = 8'h5A;
        a_req = 1'b0;

        // One frame per vector: round-robin, starvation, sd_ready gating.
        for (int i = 0; i < 12; i++) begin
            a_req = tbl[i].a; b_req = tbl[i].b; c_req = tbl[i].c;
            b_we = tbl[i].bwe; sd_ready = tbl[i].rdy; cur_rd = tbl[i].rd;
            go_ph(12);
            chk($sformatf("v%0d grant", i), grant, tbl[i].g);
            chk($sformatf("v%0d sd_we", i), sd_we, tbl[i].we);
            if (tbl[i].g != 2'd0) chk($sformatf("v%0d sd_adr", i), sd_adr, tadr[tbl[i].g]);
            if (tbl[i].we)        chk($sformatf("v%0d sd_di", i), sd_di, tbl[i].di);
            go_ph(19);
            chk($sformatf("v%0d acks", i), {a_ack, b_ack, c_ack}, tbl[i].ack);
            if (!tbl[i].we) begin
                if (tbl[i].ack[2]) exp_rd[0] = tbl[i].rd;
                if (tbl[i].ack[1]) exp_rd[1] = tbl[i].rd;
                if (tbl[i].ack[0]) exp_rd[2] = tbl[i].rd;
            end
            chk($sformatf("v%0d rdata", i), {a_rdata, b_rdata, c_rdata}, {exp_rd[0], exp_rd[1], exp_rd[2]});
        end

        // sync during a B slot abandons it; B comes back next frame and is acked once.
        a_req = 0; c_req = 0; b_req = 1; b_we = 0; sd_ready = 1; cur_rd = 8'h77;
        clr_cnt();
        go_ph(12);
        chk("t4 grant B", grant, 2);
        go_ph(14);
        force_sync = 1'b1;
        step();
        chk("t4 abort grant", grant, 0);
        chk("t4 abort sd_we", sd_we, 0);
        go_ph(12);
        chk("t4 regrant B", grant, 2);
        go_ph(19);
        chk("t4 b_ack count", ack_cnt[1], 1);
        chk("t4 other acks", ack_cnt[0] + ack_cnt[2], 0);
        chk("t4 b_rdata", b_rdata, 8'h77);
        b_req = 0;

        // Reset in the middle of a C write.
        c_req = 1; c_we = 1;
        clr_cnt();
        go_ph(12);
        chk("t6 grant C", grant, 3);
        chk("t6 sd_we", sd_we, 1);
        chk("t6 sd_di", sd_di, 8'hC3);
        go_ph(15);
        reset = 1'b1;
        step();
        chk("t6 rst sd_we", sd_we, 0);
        chk("t6 rst grant", grant, 0);
        chk("t6 rst sd_adr", sd_adr, 0);
        chk("t6 rst sd_di", sd_di, 0);
        chk("t6 rst rdata", {a_rdata, b_rdata, c_rdata}, 0);
        for (int k = 0; k < 3; k++) exp_rd[k] = 8'h00;
        c_req = 0; c_we = 0;
        step();
        reset = 1'b0;
        go_ph(19);
        chk("t6 c_ack never", ack_cnt[2], 0);

        // Request dropped mid-slot: slot finishes silently.
        a_req = 1; cur_rd = 8'h99;
        clr_cnt();
        go_ph(12);
        chk("drop grant A", grant, 1);
        go_ph(14);
        a_req = 0;
        go_ph(19);
        chk("drop a_ack", ack_cnt[0], 0);
        chk("drop grant cleared", grant, 0);
        chk("drop a_rdata held", a_rdata, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
